// File: rtl/cache_mem_arbiter_pkg.sv
// cache_mem_arbiter_pkg: memory port types and arbiter state/owner encodings
package cache_mem_arbiter_pkg;
  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
    logic         valid;
  } mem_req_type;
  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_data_type;
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} arb_state_type;
  typedef logic [1:0] arb_owner_type;
  localparam arb_owner_type ARB_OWNER_IC = 2'b01;
  localparam arb_owner_type ARB_OWNER_DC = 2'b10;
endpackage

// File: rtl/cache_mem_arbiter_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc,
  output logic [W-1:0] value
);
  always_ff @(posedge clk_i)
    value <= rst_i ? '0 : value + W'(inc && value != '1);
endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: round-robin icache/dcache owner of the single memory port.
// Define ARB_PERF_CNT_EN to add grant and wait performance counters.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  mem_req_type   ic_req_i,
  input  mem_req_type   dc_req_i,
  output mem_data_type  ic_res_o,
  output mem_data_type  dc_res_o,
  output mem_req_type   mem_req_o,
  input  mem_data_type  mem_res_i,
  output arb_owner_type owner_o,
  output logic          err_o
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] ic_grant_cnt_o,
  output logic [CNT_W-1:0] dc_grant_cnt_o,
  output logic [CNT_W-1:0] wait_cnt_o
`endif
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  arb_state_type state, nxt;
  mem_req_type   req_q;
  logic          last_dc, pick_i, pick_d, grant, done, waiting;
  logic [TW-1:0] to_cnt;
  always_comb begin
    pick_i  = ic_req_i.valid && (!dc_req_i.valid || last_dc);
    pick_d  = dc_req_i.valid && !pick_i;
    grant   = state == IDLE && (pick_i || pick_d);
    done    = state != IDLE && mem_res_i.ready;
    waiting = state != IDLE && !mem_res_i.ready;
    nxt     = state == IDLE ? (pick_i ? GRANT_I : pick_d ? GRANT_D : IDLE) : done ? IDLE : state;
  end
  // completion returns to IDLE, so the still-asserted requester waits one bubble
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      req_q   <= '0;
      last_dc <= 1'b1;
      err_o   <= 1'b0;
    end else begin
      state <= nxt;
      if (grant) begin
        req_q   <= pick_i ? ic_req_i : dc_req_i;
        last_dc <= pick_d;
      end else if (done) req_q <= '0;
      err_o <= err_o || (waiting && to_cnt >= TW'(TIMEOUT_CYCLES - 1));
    end
  end
  sat_counter #(.W(TW)) u_timeout (
    .clk_i, .rst_i(rst_i || done), .inc(waiting), .value(to_cnt)
  );
  assign mem_req_o = req_q;
  assign owner_o   = state == GRANT_I ? ARB_OWNER_IC : state == GRANT_D ? ARB_OWNER_DC : '0;
  assign ic_res_o  = state == GRANT_I ? mem_res_i : '0;
  assign dc_res_o  = state == GRANT_D ? mem_res_i : '0;
`ifdef ARB_PERF_CNT_EN
  sat_counter #(.W(CNT_W)) u_ic_cnt (
    .clk_i, .rst_i, .inc(grant && pick_i), .value(ic_grant_cnt_o)
  );
  sat_counter #(.W(CNT_W)) u_dc_cnt (
    .clk_i, .rst_i, .inc(grant && pick_d), .value(dc_grant_cnt_o)
  );
  sat_counter #(.W(CNT_W)) u_wait_cnt (
    .clk_i, .rst_i,
    .inc((ic_req_i.valid && state != GRANT_I) || (dc_req_i.valid && state != GRANT_D)),
    .value(wait_cnt_o)
  );
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif
endmodule
